// File: rtl/learn_costs.sv
// rtl/learn_costs.sv - neighbour-cost learning engine for the cluster-routing node
//
// On each en pulse, searches the neighbour table in byte memory for fsourceID.
// A hit rewrites battery/value/cluster of that entry in place; a miss appends a
// new entry seeded with initial_epsilon and bumps the neighbour count. While busy
// this block is the only memory master.
//
// Ports:
//   clock, nrst      clock, asynchronous active-low reset
//   en               start pulse, sampled only when idle
//   fsourceID .. initial_epsilon   frame fields, latched on en
//   address, wr_en, data_out        memory request (registered outputs)
//   data_in          memory read data, valid one cycle after address
//   done             one-cycle completion pulse
module learn_costs #(
  parameter int WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] NBR_COUNT_ADDR = 16'h0100,
  parameter logic [WORD_WIDTH-1:0] NBR_TABLE_BASE = 16'h0102,
  parameter int ENTRY_BYTES = 10,
  parameter int MAX_NBRS = 8
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] fsourceID,
  input  logic [WORD_WIDTH-1:0] fbatteryStat,
  input  logic [WORD_WIDTH-1:0] fValue,
  input  logic [WORD_WIDTH-1:0] fclusterID,
  input  logic [WORD_WIDTH-1:0] initial_epsilon,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] STRIDE = WORD_WIDTH'(ENTRY_BYTES);
  localparam logic [WORD_WIDTH-1:0] CAP    = WORD_WIDTH'(MAX_NBRS);
  localparam logic [WORD_WIDTH-1:0] TWO    = WORD_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] ONE    = WORD_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WT_CNT, RD_ID, WT_ID, UPDATE, APPEND, DONE
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] id_q, bat_q, val_q, clu_q, eps_q;
  logic [WORD_WIDTH-1:0] cnt, idx;
  logic [2:0]            wcnt;

  // Address arithmetic is intentionally modulo 2^WORD_WIDTH.
  logic [WORD_WIDTH-1:0] ent_addr, app_addr;
  assign ent_addr = NBR_TABLE_BASE + idx * STRIDE;
  assign app_addr = NBR_TABLE_BASE + cnt * STRIDE;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      address  <= '0;
      wr_en    <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      id_q     <= '0;
      bat_q    <= '0;
      val_q    <= '0;
      clu_q    <= '0;
      eps_q    <= '0;
      cnt      <= '0;
      idx      <= '0;
      wcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (en) begin
            id_q    <= fsourceID;
            bat_q   <= fbatteryStat;
            val_q   <= fValue;
            clu_q   <= fclusterID;
            eps_q   <= initial_epsilon;
            address <= NBR_COUNT_ADDR;
            state   <= RD_CNT;
          end
        end
        RD_CNT: state <= WT_CNT;
        WT_CNT: begin
          cnt <= data_in;
          idx <= '0;
          if (data_in == '0) begin
            // Empty table: first append write goes straight out.
            address  <= NBR_TABLE_BASE;
            data_out <= id_q;
            wr_en    <= 1'b1;
            wcnt     <= '0;
            state    <= APPEND;
          end else begin
            address <= NBR_TABLE_BASE;
            state   <= RD_ID;
          end
        end
        RD_ID: state <= WT_ID;
        WT_ID: begin
          if (data_in == id_q) begin
            address  <= ent_addr + TWO;
            data_out <= bat_q;
            wr_en    <= 1'b1;
            wcnt     <= '0;
            state    <= UPDATE;
          end else if (idx + ONE == cnt) begin
            if (cnt >= CAP) begin
              // Table full: drop the new neighbour without touching memory.
              done  <= 1'b1;
              state <= DONE;
            end else begin
              address  <= app_addr;
              data_out <= id_q;
              wr_en    <= 1'b1;
              wcnt     <= '0;
              state    <= APPEND;
            end
          end else begin
            idx     <= idx + ONE;
            address <= ent_addr + STRIDE;
            state   <= RD_ID;
          end
        end
        UPDATE: begin
          wcnt <= wcnt + 3'd1;
          case (wcnt)
            3'd0: begin address <= address + TWO; data_out <= val_q; end
            3'd1: begin address <= address + TWO; data_out <= clu_q; end
            default: begin wr_en <= 1'b0; done <= 1'b1; state <= DONE; end
          endcase
        end
        APPEND: begin
          wcnt <= wcnt + 3'd1;
          case (wcnt)
            3'd0: begin address <= address + TWO; data_out <= bat_q; end
            3'd1: begin address <= address + TWO; data_out <= val_q; end
            3'd2: begin address <= address + TWO; data_out <= clu_q; end
            3'd3: begin address <= address + TWO; data_out <= eps_q; end
            3'd4: begin address <= NBR_COUNT_ADDR; data_out <= cnt + ONE; end
            default: begin wr_en <= 1'b0; done <= 1'b1; state <= DONE; end
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_learn_costs.sv
// tb/tb_learn_costs.sv - table-driven bench for learn_costs
module tb_learn_costs;

  localparam logic [15:0] BASE = 16'h0102;
  localparam logic [15:0] CNTA = 16'h0100;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] fsourceID = '0, fbatteryStat = '0, fValue = '0, fclusterID = '0;
  logic [15:0] initial_epsilon = '0;
  logic [15:0] address, data_out, data_in;
  logic        wr_en, done;

  logic [7:0]  mem [2048];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0, pre_d = '0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  learn_costs dut (
    .clock(clock), .nrst(nrst), .en(en),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .initial_epsilon(initial_epsilon),
    .address(address), .wr_en(wr_en), .data_in(data_in),
    .data_out(data_out), .done(done)
  );

  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_a[10:0]]         <= pre_d[15:8];
      mem[pre_a[10:0] + 11'd1] <= pre_d[7:0];
    end else if (wr_en) begin
      mem[address[10:0]]         <= data_out[15:8];
      mem[address[10:0] + 11'd1] <= data_out[7:0];
    end
    data_in <= {mem[address[10:0]], mem[address[10:0] + 11'd1]};
  end

  typedef struct {
    int          cnt;
    logic [7:0][15:0] ids;
    logic [15:0] id, bat, val, clu, eps;
    int          exp_cnt;
    int          exp_slot;
    logic [15:0] exp_eps;
    int          exp_lat;
    int          exp_writes;
    int          exp_probes;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mkv(int cnt, logic [15:0] id, logic [15:0] bat,
                               logic [15:0] val, logic [15:0] clu, logic [15:0] eps,
                               int exp_cnt, int slot, logic [15:0] exp_eps,
                               int lat, int writes, int probes);
    vec_t v;
    v.cnt = cnt; v.ids = '0; v.id = id; v.bat = bat; v.val = val; v.clu = clu;
    v.eps = eps; v.exp_cnt = exp_cnt; v.exp_slot = slot; v.exp_eps = exp_eps;
    v.exp_lat = lat; v.exp_writes = writes; v.exp_probes = probes;
    return v;
  endfunction

  function automatic logic [15:0] rd_word(logic [15:0] a);
    return {mem[a[10:0]], mem[a[10:0] + 11'd1]};
  endfunction

  // Preloaded entry s holds {ids[s], 0x100+s, 0x200+s, 0x300+s, 0x400+s}.
  function automatic logic [15:0] pat(vec_t v, int s, int w);
    if (w == 0) return v.ids[s];
    return 16'(w * 256 + s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_a = a; pre_d = d;
  endtask

  task automatic load_table(input vec_t v);
    wr_word(CNTA, 16'(v.cnt));
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 5; w++)
        wr_word(BASE + 16'(s * 10 + w * 2), (s < v.cnt) ? pat(v, s, w) : 16'hEEEE);
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] id, input logic [15:0] bat,
                        input logic [15:0] val, input logic [15:0] clu,
                        input logic [15:0] eps, input int poke_at,
                        output int lat, output int writes, output int probes);
    logic [15:0] prev;
    bit seen;
    @(negedge clock);
    en = 1'b1; fsourceID = id; fbatteryStat = bat; fValue = val;
    fclusterID = clu; initial_epsilon = eps;
    @(negedge clock);
    en = 1'b0; fsourceID = 16'hDEAD; fbatteryStat = 16'hBEEF; fValue = 16'h5555;
    fclusterID = 16'h6666; initial_epsilon = 16'h7777;
    lat = 1; writes = 0; probes = 0; prev = address; seen = 0;
    while (lat < 300) begin
      if (done) begin seen = 1; break; end
      if (wr_en) writes++;
      if (!wr_en && address >= BASE && address < BASE + 16'd80 && address != prev)
        probes++;
      prev = address;
      en = (lat == poke_at);
      if (lat == poke_at) begin fsourceID = 16'd7; fbatteryStat = 16'h9999; end
      @(negedge clock);
      lat++;
    end
    en = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, writes, probes;
    int k;
    vec_t v;

    vecs[0] = mkv(2, 16'd31, 16'd5, 16'd10, 16'd11, 16'd1, 2, 1, 16'h0401, 10, 3, 2);
    vecs[0].ids[0] = 16'd7; vecs[0].ids[1] = 16'd31;
    vecs[1] = mkv(2, 16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 3, 2, 16'd1, 13, 6, 2);
    vecs[1].ids[0] = 16'd7; vecs[1].ids[1] = 16'd31;
    vecs[2] = mkv(0, 16'd9, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1, 0, 16'h0D0D, 9, 6, 0);
    vecs[3] = mkv(8, 16'd99, 16'd1, 16'd2, 16'd3, 16'd4, 8, -1, 16'd0, -1, 0, 8);
    for (int s = 0; s < 8; s++) vecs[3].ids[s] = 16'(10 * (s + 1));
    vecs[4] = mkv(3, 16'd42, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3, 0, 16'h0400, 8, 3, 1);
    vecs[4].ids[0] = 16'd42; vecs[4].ids[1] = 16'd43; vecs[4].ids[2] = 16'd44;
    vecs[5] = mkv(3, 16'd5, 16'hA1, 16'hA2, 16'hA3, 16'hA4, 3, 0, 16'h0400, 8, 3, 1);
    vecs[5].ids[0] = 16'd5; vecs[5].ids[1] = 16'd5; vecs[5].ids[2] = 16'd6;
    vecs[6] = mkv(2, 16'h8234, 16'hB1, 16'hB2, 16'hB3, 16'hB4, 2, 1, 16'h0401, 10, 3, 2);
    vecs[6].ids[0] = 16'h1234; vecs[6].ids[1] = 16'h8234;
    vecs[7] = mkv(8, 16'd80, 16'hC1, 16'hC2, 16'hC3, 16'hC4, 8, 7, 16'h0407, 22, 3, 8);
    for (int s = 0; s < 8; s++) vecs[7].ids[s] = 16'(10 * (s + 1));
    vecs[8] = mkv(7, 16'hFFFF, 16'hD1, 16'hD2, 16'hD3, 16'hD4, 8, 7, 16'hD4, 23, 6, 7);
    for (int s = 0; s < 7; s++) vecs[8].ids[s] = 16'(10 * (s + 1));

    repeat (3) @(negedge clock);
    chk("reset_address", address, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_done", done, 0);
    @(negedge clock);
    nrst = 1'b1;

    for (int t = 0; t < 9; t++) begin
      v = vecs[t];
      load_table(v);
      run_op(v.id, v.bat, v.val, v.clu, v.eps, -1, lat, writes, probes);
      if (v.exp_lat >= 0) chk($sformatf("v%0d_latency", t), lat, v.exp_lat);
      chk($sformatf("v%0d_writes", t), writes, v.exp_writes);
      chk($sformatf("v%0d_id_reads", t), probes, v.exp_probes);
      chk($sformatf("v%0d_count", t), rd_word(CNTA), v.exp_cnt);
      if (v.exp_slot >= 0) begin
        chk($sformatf("v%0d_id", t), rd_word(BASE + 16'(v.exp_slot * 10)), v.id);
        chk($sformatf("v%0d_bat", t), rd_word(BASE + 16'(v.exp_slot * 10 + 2)), v.bat);
        chk($sformatf("v%0d_val", t), rd_word(BASE + 16'(v.exp_slot * 10 + 4)), v.val);
        chk($sformatf("v%0d_clu", t), rd_word(BASE + 16'(v.exp_slot * 10 + 6)), v.clu);
        chk($sformatf("v%0d_eps", t), rd_word(BASE + 16'(v.exp_slot * 10 + 8)), v.exp_eps);
      end
      for (int s = 0; s < v.cnt; s++)
        if (s != v.exp_slot)
          for (int w = 0; w < 5; w++)
            chk($sformatf("v%0d_keep_e%0d_w%0d", t, s, w),
                rd_word(BASE + 16'(s * 10 + w * 2)), pat(v, s, w));
    end

    // Second en during the search is ignored; then back-to-back ops.
    load_table(vecs[0]);
    run_op(16'd31, 16'd5, 16'd10, 16'd11, 16'd1, 3, lat, writes, probes);
    chk("poke_latency", lat, 10);
    chk("poke_e1_bat", rd_word(BASE + 16'd12), 16'd5);
    chk("poke_e0_bat", rd_word(BASE + 16'd2), 16'h0100);
    run_op(16'd31, 16'd6, 16'd20, 16'd21, 16'd1, -1, lat, writes, probes);
    chk("b2b_latency", lat, 10);
    chk("b2b_e1_bat", rd_word(BASE + 16'd12), 16'd6);
    chk("b2b_e1_val", rd_word(BASE + 16'd14), 16'd20);
    chk("b2b_count", rd_word(CNTA), 2);

    // Reset in the middle of UPDATE.
    load_table(vecs[0]);
    @(negedge clock);
    en = 1'b1; fsourceID = 16'd31; fbatteryStat = 16'hAAAA; fValue = 16'hBBBB;
    fclusterID = 16'hCCCC;
    @(negedge clock);
    en = 1'b0;
    k = 0;
    while (!wr_en && k < 50) begin @(negedge clock); k++; end
    chk("rst_reach_update", wr_en, 1);
    @(negedge clock);
    #1 nrst = 1'b0;
    #1;
    chk("rst_async_address", address, 0);
    chk("rst_async_wr_en", wr_en, 0);
    chk("rst_async_data_out", data_out, 0);
    chk("rst_async_done", done, 0);
    @(negedge clock);
    chk("rst_kept_bat", rd_word(BASE + 16'd12), 16'hAAAA);
    chk("rst_unwritten_val", rd_word(BASE + 16'd14), 16'h0201);
    nrst = 1'b1;
    run_op(16'd7, 16'h0077, 16'h0088, 16'h0099, 16'd1, -1, lat, writes, probes);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_e0_bat", rd_word(BASE + 16'd2), 16'h0077);
    chk("post_rst_e0_clu", rd_word(BASE + 16'd6), 16'h0099);
    chk("post_rst_count", rd_word(CNTA), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
